muldiv_sequencer: RTL

- Multi-cycle controller for the RV32M multiply/divide operations. It runs alongside the single-cycle ALU in the execute stage.
- Accepts one M-extension operation per handshake and runs an iterative shift-add multiply or restoring divide over XLEN cycles.
- Stalls the execute stage while busy and presents a held result to writeback until acknowledged.

---
 rtl/muldiv_sequencer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Iterative RV32M multiply/divide controller. Runs shift-add
//               multiply or restoring divide over XLEN cycles, stalls the
//               execute stage while busy and holds the result until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_in,
  output logic            ready_in,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            busy,
  output logic            valid_out,
  input  logic            result_ready,
  output logic [XLEN-1:0] result
);

  // FSM encoding
  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_CALC  = 2'd1;
  localparam logic [1:0] c_FIXUP = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  // func3 encodings
  localparam logic [2:0] c_F_MUL    = 3'b000;
  localparam logic [2:0] c_F_MULH   = 3'b001;
  localparam logic [2:0] c_F_MULHSU = 3'b010;
  localparam logic [2:0] c_F_MULHU  = 3'b011;
  localparam logic [2:0] c_F_DIV    = 3'b100;
  localparam logic [2:0] c_F_DIVU   = 3'b101;
  localparam logic [2:0] c_F_REM    = 3'b110;
  localparam logic [2:0] c_F_REMU   = 3'b111;

  localparam logic [CNT_W-1:0] c_CNT_LOAD = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(1);
  localparam logic [XLEN-1:0]  c_MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  // State and datapath registers. r_acc is the 2*XLEN product register for
  // multiply ({high, multiplier}) and the {remainder, quotient} pair for divide.
  logic [1:0]        r_state;
  logic [2:0]        r_func3;
  logic              r_neg_a;
  logic              r_neg_b;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opb;
  logic [CNT_W-1:0]  r_cnt;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_rs1_signed;
  logic              w_rs2_signed;
  logic              w_sa;
  logic              w_sb;
  logic [XLEN-1:0]   w_abs1;
  logic [XLEN-1:0]   w_abs2;
  logic              w_div0;
  logic              w_ovf;
  logic              w_fast;
  logic [XLEN-1:0]   w_fast_result;
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN-1:0]   w_div_diff;
  logic              w_div_ok;
  logic [2*XLEN-1:0] w_div_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fix_result;

  assign ready_in  = (r_state == c_IDLE);
  assign busy      = (r_state == c_CALC) || (r_state == c_FIXUP);
  assign valid_out = (r_state == c_DONE);
  assign result    = r_result;

  // flush in IDLE suppresses the transfer even though ready_in is high
  assign w_accept = valid_in && ready_in && !flush;

  // Operand signedness: rs1 is signed for MULH/MULHSU/DIV/REM, rs2 for MULH/DIV/REM
  assign w_rs1_signed = (func3 == c_F_MULH) || (func3 == c_F_MULHSU) ||
                        (func3 == c_F_DIV)  || (func3 == c_F_REM);
  assign w_rs2_signed = (func3 == c_F_MULH) || (func3 == c_F_DIV) ||
                        (func3 == c_F_REM);
  assign w_sa   = rs1[XLEN-1] && w_rs1_signed;
  assign w_sb   = rs2[XLEN-1] && w_rs2_signed;
  assign w_abs1 = w_sa ? (~rs1 + 1'b1) : rs1;
  assign w_abs2 = w_sb ? (~rs2 + 1'b1) : rs2;

  // Divide-by-zero and signed overflow bypass the iterative datapath
  assign w_div0 = (rs2 == '0);
  assign w_ovf  = (rs1 == c_MIN_NEG) && (rs2 == '1);
  assign w_fast = func3[2] && (w_div0 || (w_ovf && !func3[0]));

  // Fast-path result: quotient all ones / remainder = dividend on /0;
  // overflow gives quotient MIN_NEG and remainder 0
  always_comb begin
    w_fast_result = '0;
    if (w_div0) begin
      w_fast_result = func3[1] ? rs1 : '1;
    end else begin
      w_fast_result = func3[1] ? '0 : c_MIN_NEG;
    end
  end

  assign w_hi = r_acc[2*XLEN-1:XLEN];
  assign w_lo = r_acc[XLEN-1:0];

  // Shift-add step: carry out of the high-half add is kept and shifted in
  assign w_mul_sum  = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, w_lo[XLEN-1:1]};

  // Restoring step: the shifted remainder can need XLEN+1 bits, but a
  // successful difference always fits in XLEN because remainder < divisor
  assign w_div_shift = {w_hi, w_lo[XLEN-1]};
  assign w_div_ok    = (w_div_shift >= {1'b0, r_opb});
  assign w_div_diff  = w_div_shift[XLEN-1:0] - r_opb;
  assign w_div_next  = {(w_div_ok ? w_div_diff : w_div_shift[XLEN-1:0]),
                        w_lo[XLEN-2:0], w_div_ok};

  // Sign correction on the magnitude results
  assign w_prod = (r_neg_a ^ r_neg_b) ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = (r_neg_a ^ r_neg_b) ? (~w_lo + 1'b1) : w_lo;
  assign w_rem  = r_neg_a ? (~w_hi + 1'b1) : w_hi;

  // Output selection by latched operation
  always_comb begin
    w_fix_result = '0;
    case (r_func3)
      c_F_MUL:                         w_fix_result = w_prod[XLEN-1:0];
      c_F_MULH, c_F_MULHSU, c_F_MULHU: w_fix_result = w_prod[2*XLEN-1:XLEN];
      c_F_DIV, c_F_DIVU:               w_fix_result = w_quo;
      c_F_REM, c_F_REMU:               w_fix_result = w_rem;
      default:                         w_fix_result = '0;
    endcase
  end

  // Sequencer FSM and datapath; flush has priority over every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= c_IDLE;
      r_func3  <= '0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_acc    <= '0;
      r_opb    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (flush) begin
      r_state  <= c_IDLE;
      r_result <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_func3 <= func3;
            r_neg_a <= w_sa;
            r_neg_b <= w_sb;
            r_cnt   <= c_CNT_LOAD;
            if (func3[2]) begin
              // divide: dividend enters the quotient half, divisor in r_opb
              r_acc <= {{XLEN{1'b0}}, w_abs1};
              r_opb <= w_abs2;
            end else begin
              // multiply: multiplier in the low half, multiplicand in r_opb
              r_acc <= {{XLEN{1'b0}}, w_abs2};
              r_opb <= w_abs1;
            end
            if (w_fast) begin
              r_result <= w_fast_result;
              r_state  <= c_DONE;
            end else begin
              r_state  <= c_CALC;
            end
          end
        end
        c_CALC: begin
          r_acc <= r_func3[2] ? w_div_next : w_mul_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == c_CNT_LAST) begin
            r_state <= c_FIXUP;
          end
        end
        c_FIXUP: begin
          r_result <= w_fix_result;
          r_state  <= c_DONE;
        end
        c_DONE: begin
          if (result_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
